// File: rtl/bus_dma_if.sv
// CPU register port and initiator bus of the DMA engine, bundled as one interface.
// master is the DMA's own view; slave is the CPU/responder side that faces it.
interface bus_dma_if;
  logic [2:0]  s_a;
  logic [31:0] s_d;
  logic        s_we;
  logic [31:0] s_spo;
  logic [31:0] m_a;
  logic [31:0] m_d;
  logic        m_we;
  logic        m_rd;
  logic [31:0] m_spo;
  logic        m_ready;
  logic        irq;

  modport master (
    input  s_a, s_d, s_we, m_spo, m_ready,
    output s_spo, m_a, m_d, m_we, m_rd, irq
  );

  modport slave (
    output s_a, s_d, s_we, m_spo, m_ready,
    input  s_spo, m_a, m_d, m_we, m_rd, irq
  );
endinterface

// File: rtl/bus_dma.sv
// Word-copy DMA: one read beat then one write beat per word, 2 cycles + responder waits each.
// Bus strobes and address/data are registered and held until m_ready; abort lands on a beat boundary.
module bus_dma #(
  parameter int LEN_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  bus_dma_if.master  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       src, dst;
  logic [LEN_W-1:0]  len;
  logic              irq_en, done, aborted, abort_pend;
  logic [31:0]       cur_src, cur_dst, data_buf;
  logic [LEN_W-1:0]  remain;
  logic [31:0]       m_a_q, m_d_q;
  logic              m_rd_q, m_we_q;

  logic              done_nxt, aborted_nxt, pend_nxt;
  logic [31:0]       cur_src_nxt, cur_dst_nxt, buf_nxt, m_a_nxt, m_d_nxt;
  logic [LEN_W-1:0]  remain_nxt;
  logic              m_rd_nxt, m_we_nxt;

  logic              busy, wr_ctrl, start_req, clr_req, abort_req;
  logic [31:0]       len_ext;

  assign busy      = (state != IDLE);
  assign wr_ctrl   = bus.s_we && (bus.s_a == 3'd3);
  assign start_req = wr_ctrl && bus.s_d[0];
  assign clr_req   = wr_ctrl && bus.s_d[2];
  assign abort_req = wr_ctrl && bus.s_d[3];

  always_comb begin
    len_ext = '0;
    len_ext[LEN_W-1:0] = len;
  end

  always_comb begin
    bus.s_spo = '0;
    case (bus.s_a)
      3'd0:    bus.s_spo = src;
      3'd1:    bus.s_spo = dst;
      3'd2:    bus.s_spo = len_ext;
      3'd3:    bus.s_spo = {28'd0, irq_en, aborted, done, busy};
      default: bus.s_spo = '0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    cur_src_nxt = cur_src;
    cur_dst_nxt = cur_dst;
    remain_nxt  = remain;
    buf_nxt     = data_buf;
    done_nxt    = done & ~clr_req;
    aborted_nxt = aborted;
    pend_nxt    = abort_pend | (busy & abort_req);
    m_rd_nxt    = 1'b0;
    m_we_nxt    = 1'b0;
    m_a_nxt     = m_a_q;
    m_d_nxt     = m_d_q;

    // done_nxt is assigned after the clear term so a same-cycle set wins
    case (state)
      IDLE: begin
        if (start_req) begin
          aborted_nxt = 1'b0;
          if (len != '0) begin
            cur_src_nxt = src;
            cur_dst_nxt = dst;
            remain_nxt  = len;
            done_nxt    = 1'b0;
            state_nxt   = READ;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      READ: begin
        if (bus.m_ready) begin
          buf_nxt = bus.m_spo;
          if (pend_nxt) begin
            state_nxt   = IDLE;
            aborted_nxt = 1'b1;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        if (bus.m_ready) begin
          cur_src_nxt = cur_src + 32'd4;
          cur_dst_nxt = cur_dst + 32'd4;
          remain_nxt  = remain - LEN_W'(1);
          if (pend_nxt) begin
            state_nxt   = IDLE;
            aborted_nxt = 1'b1;
          end else if (remain == LEN_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = READ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == IDLE) pend_nxt = 1'b0;

    // Bus outputs are registered from the next state so they change only on beat edges
    case (state_nxt)
      READ: begin
        m_rd_nxt = 1'b1;
        m_a_nxt  = cur_src_nxt;
      end
      WRITE: begin
        m_we_nxt = 1'b1;
        m_a_nxt  = cur_dst_nxt;
        m_d_nxt  = buf_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cur_src    <= '0;
      cur_dst    <= '0;
      remain     <= '0;
      data_buf   <= '0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      abort_pend <= 1'b0;
      m_rd_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_a_q      <= '0;
      m_d_q      <= '0;
    end else begin
      state      <= state_nxt;
      cur_src    <= cur_src_nxt;
      cur_dst    <= cur_dst_nxt;
      remain     <= remain_nxt;
      data_buf   <= buf_nxt;
      done       <= done_nxt;
      aborted    <= aborted_nxt;
      abort_pend <= pend_nxt;
      m_rd_q     <= m_rd_nxt;
      m_we_q     <= m_we_nxt;
      m_a_q      <= m_a_nxt;
      m_d_q      <= m_d_nxt;
    end
  end

  // Programming registers are frozen while a transfer runs; irq_en is not
  always_ff @(posedge clk) begin
    if (!rst) begin
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      irq_en <= 1'b0;
    end else begin
      if (bus.s_we && !busy) begin
        case (bus.s_a)
          3'd0:    src <= {bus.s_d[31:2], 2'b00};
          3'd1:    dst <= {bus.s_d[31:2], 2'b00};
          3'd2:    len <= bus.s_d[LEN_W-1:0];
          default: ;
        endcase
      end
      if (wr_ctrl) irq_en <= bus.s_d[1];
    end
  end

  assign bus.m_a  = m_a_q;
  assign bus.m_d  = m_d_q;
  assign bus.m_rd = m_rd_q;
  assign bus.m_we = m_we_q;
  assign bus.irq  = done & irq_en;

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: a memory responder with programmable wait states logs every beat.
module tb_bus_dma;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_dma_if bus ();

  bus_dma #(.LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          wait_cycles = 0;
  logic        overlap = 1'b0;
  logic        beat_wr[$];
  logic [31:0] beat_a[$];
  logic [31:0] beat_d[$];

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {a[15:0], 16'hBEEF};
  endfunction

  // Responder: completes each beat after wait_cycles idle cycles, logging it
  initial begin
    int cnt;
    cnt = 0;
    bus.m_ready = 1'b0;
    bus.m_spo   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.m_rd && bus.m_we) overlap = 1'b1;
      if (rst && (bus.m_rd || bus.m_we)) begin
        if (cnt >= wait_cycles) begin
          bus.m_ready = 1'b1;
          bus.m_spo   = bus.m_rd ? rdata(bus.m_a) : 32'h0;
          beat_wr.push_back(bus.m_we);
          beat_a.push_back(bus.m_a);
          beat_d.push_back(bus.m_we ? bus.m_d : bus.m_spo);
          cnt = 0;
        end else begin
          bus.m_ready = 1'b0;
          cnt++;
        end
      end else begin
        bus.m_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no summary by 500000, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    bus.s_a  = a;
    bus.s_d  = d;
    bus.s_we = 1'b1;
    tick();
    bus.s_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    bus.s_a = a;
    #1;
    v = bus.s_spo;
  endtask

  task automatic clear_log;
    beat_wr.delete();
    beat_a.delete();
    beat_d.delete();
  endtask

  task automatic test_reset;
    logic [31:0] v;
    bus.s_a = '0; bus.s_d = '0; bus.s_we = 1'b0;
    rst = 1'b0;
    tick(); tick();
    checks++; if (bus.m_rd !== 1'b0) begin errors++; $display("FAIL reset_m_rd: got %b expected 0", bus.m_rd); end
    checks++; if (bus.m_we !== 1'b0) begin errors++; $display("FAIL reset_m_we: got %b expected 0", bus.m_we); end
    checks++; if (bus.m_a !== 32'h0) begin errors++; $display("FAIL reset_m_a: got %h expected 0", bus.m_a); end
    checks++; if (bus.m_d !== 32'h0) begin errors++; $display("FAIL reset_m_d: got %h expected 0", bus.m_d); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
    rst = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) continue;
      rd(3'(i), v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0", i, v); end
    end
  endtask

  task automatic test_copy;
    logic [31:0] v;
    logic        ew[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ea[6] = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008};
    logic [31:0] ed[6] = '{32'h1000BEEF, 32'h1000BEEF, 32'h1004BEEF, 32'h1004BEEF, 32'h1008BEEF, 32'h1008BEEF};
    clear_log();
    wait_cycles = 0;
    cpu_write(0, 32'h1000);
    cpu_write(1, 32'h2000);
    cpu_write(2, 32'd3);
    cpu_write(3, 32'h1);
    checks++;
    if (bus.m_rd !== 1'b1 || bus.m_we !== 1'b0 || bus.m_a !== 32'h1000) begin
      errors++; $display("FAIL copy_first_rd: got rd=%b we=%b a=%h expected rd=1 we=0 a=00001000", bus.m_rd, bus.m_we, bus.m_a);
    end
    repeat (5) tick();
    rd(3, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL copy_busy_at5: got %h expected 00000001", v); end
    tick();
    rd(3, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL copy_done_at6: got %h expected 00000002", v); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL copy_irq: got %b expected 0", bus.irq); end
    checks++; if (beat_a.size() != 6) begin errors++; $display("FAIL copy_beats: got %0d expected 6", beat_a.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= beat_a.size()) begin
        errors++; $display("FAIL copy_beat%0d: got none expected a=%h", i, ea[i]);
      end else if (beat_wr[i] !== ew[i] || beat_a[i] !== ea[i] || beat_d[i] !== ed[i]) begin
        errors++; $display("FAIL copy_beat%0d: got wr=%b a=%h d=%h expected wr=%b a=%h d=%h",
                           i, beat_wr[i], beat_a[i], beat_d[i], ew[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_wait;
    logic [31:0] v;
    cpu_write(3, 32'h4);
    clear_log();
    wait_cycles = 5;
    cpu_write(0, 32'h3000);
    cpu_write(1, 32'h4000);
    cpu_write(2, 32'd1);
    cpu_write(3, 32'h1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus.m_rd !== 1'b1 || bus.m_we !== 1'b0 || bus.m_a !== 32'h3000) begin
        errors++; $display("FAIL wait_rd_hold%0d: got rd=%b we=%b a=%h expected rd=1 we=0 a=00003000", i, bus.m_rd, bus.m_we, bus.m_a);
      end
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.m_we !== 1'b1 || bus.m_rd !== 1'b0 || bus.m_a !== 32'h4000 || bus.m_d !== 32'h3000BEEF) begin
        errors++; $display("FAIL wait_wr_hold%0d: got we=%b rd=%b a=%h d=%h expected we=1 rd=0 a=00004000 d=3000beef",
                           i, bus.m_we, bus.m_rd, bus.m_a, bus.m_d);
      end
      tick();
    end
    rd(3, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL wait_done: got %h expected 00000002", v); end
    checks++; if (beat_a.size() != 2) begin errors++; $display("FAIL wait_beats: got %0d expected 2", beat_a.size()); end
    wait_cycles = 0;
  endtask

  task automatic test_len0;
    logic [31:0] v;
    cpu_write(3, 32'h4);
    clear_log();
    cpu_write(2, 32'd0);
    cpu_write(3, 32'h3);
    rd(3, v);
    checks++; if (v !== 32'hA) begin errors++; $display("FAIL len0_status: got %h expected 0000000a", v); end
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL len0_irq: got %b expected 1", bus.irq); end
    checks++; if (bus.m_rd !== 1'b0 || bus.m_we !== 1'b0) begin errors++; $display("FAIL len0_strobes: got rd=%b we=%b expected 0 0", bus.m_rd, bus.m_we); end
    tick();
    checks++; if (beat_a.size() != 0) begin errors++; $display("FAIL len0_beats: got %0d expected 0", beat_a.size()); end
    cpu_write(3, 32'h6);
    rd(3, v);
    checks++; if (v !== 32'h8) begin errors++; $display("FAIL len0_clear: got %h expected 00000008", v); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL len0_irq_clr: got %b expected 0", bus.irq); end
    cpu_write(3, 32'h5);
    rd(3, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL len0_set_wins: got %h expected 00000002", v); end
  endtask

  task automatic test_abort;
    logic [31:0] v;
    logic        found, idle;
    cpu_write(3, 32'h4);
    clear_log();
    wait_cycles = 2;
    cpu_write(0, 32'h5000);
    cpu_write(1, 32'h6000);
    cpu_write(2, 32'd4);
    cpu_write(3, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (bus.m_rd === 1'b1 && bus.m_a === 32'h5004) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_second_read: got none expected rd at 00005004"); end
    cpu_write(3, 32'h8);
    idle = 1'b0;
    v = '0;
    for (int i = 0; i < 50 && !idle; i++) begin
      rd(3, v);
      if (v[0] === 1'b0) idle = 1'b1;
      else tick();
    end
    checks++; if (v !== 32'h4) begin errors++; $display("FAIL abort_status: got %h expected 00000004", v); end
    repeat (5) tick();
    checks++;
    if (beat_a.size() != 3) begin
      errors++; $display("FAIL abort_beats: got %0d expected 3", beat_a.size());
    end else if (beat_wr[2] !== 1'b0 || beat_a[2] !== 32'h5004 || beat_d[2] !== 32'h5004BEEF) begin
      errors++; $display("FAIL abort_last_beat: got wr=%b a=%h d=%h expected wr=0 a=00005004 d=5004beef", beat_wr[2], beat_a[2], beat_d[2]);
    end
    checks++; if (bus.m_rd !== 1'b0 || bus.m_we !== 1'b0) begin errors++; $display("FAIL abort_strobes: got rd=%b we=%b expected 0 0", bus.m_rd, bus.m_we); end
    wait_cycles = 0;
  endtask

  task automatic test_wrap_busy;
    logic [31:0] v;
    logic        ew[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ea[4] = '{32'hFFFFFFFC, 32'h100, 32'h0, 32'h104};
    logic [31:0] ed[4] = '{32'hFFFCBEEF, 32'hFFFCBEEF, 32'h0000BEEF, 32'h0000BEEF};
    cpu_write(3, 32'h4);
    clear_log();
    wait_cycles = 0;
    cpu_write(0, 32'h1003);
    rd(0, v);
    checks++; if (v !== 32'h1000) begin errors++; $display("FAIL src_align: got %h expected 00001000", v); end
    cpu_write(0, 32'hFFFFFFFC);
    cpu_write(1, 32'h100);
    cpu_write(2, 32'd2);
    cpu_write(3, 32'h1);
    cpu_write(2, 32'd7);
    cpu_write(0, 32'h40);
    cpu_write(3, 32'h1);
    tick();
    rd(3, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL wrap_done: got %h expected 00000002", v); end
    rd(2, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL busy_len_ignored: got %h expected 00000002", v); end
    rd(0, v);
    checks++; if (v !== 32'hFFFFFFFC) begin errors++; $display("FAIL busy_src_ignored: got %h expected fffffffc", v); end
    repeat (4) tick();
    rd(3, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL busy_start_ignored: got %h expected 00000002", v); end
    checks++; if (beat_a.size() != 4) begin errors++; $display("FAIL wrap_beats: got %0d expected 4", beat_a.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= beat_a.size()) begin
        errors++; $display("FAIL wrap_beat%0d: got none expected a=%h", i, ea[i]);
      end else if (beat_wr[i] !== ew[i] || beat_a[i] !== ea[i] || beat_d[i] !== ed[i]) begin
        errors++; $display("FAIL wrap_beat%0d: got wr=%b a=%h d=%h expected wr=%b a=%h d=%h",
                           i, beat_wr[i], beat_a[i], beat_d[i], ew[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    logic        found;
    int          n;
    cpu_write(3, 32'h4);
    clear_log();
    wait_cycles = 3;
    cpu_write(0, 32'h7000);
    cpu_write(1, 32'h8000);
    cpu_write(2, 32'd3);
    cpu_write(3, 32'h3);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (bus.m_we === 1'b1) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_write: got none expected a write beat"); end
    rst = 1'b0;
    tick();
    checks++; if (bus.m_rd !== 1'b0 || bus.m_we !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: got rd=%b we=%b expected 0 0", bus.m_rd, bus.m_we); end
    checks++; if (bus.m_a !== 32'h0 || bus.m_d !== 32'h0) begin errors++; $display("FAIL rstmid_bus: got a=%h d=%h expected 0 0", bus.m_a, bus.m_d); end
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b expected 0", bus.irq); end
    for (int i = 0; i < 4; i++) begin
      rd(3'(i), v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL rstmid_reg%0d: got %h expected 0", i, v); end
    end
    n = beat_a.size();
    rst = 1'b1;
    repeat (8) tick();
    checks++; if (beat_a.size() != n) begin errors++; $display("FAIL rstmid_no_beats: got %0d expected %0d", beat_a.size(), n); end
    checks++; if (bus.m_rd !== 1'b0 || bus.m_we !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got rd=%b we=%b expected 0 0", bus.m_rd, bus.m_we); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL strobe_overlap: got %b expected 0", overlap); end
    wait_cycles = 0;
  endtask

  initial begin
    bus.s_a  = '0;
    bus.s_d  = '0;
    bus.s_we = 1'b0;
    test_reset();
    test_copy();
    test_wait();
    test_len0();
    test_abort();
    test_wrap_busy();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
